// File: rtl/pipe_pkg.sv
// Shared defaults for the valid/allowin pipeline chain.
package pipe_pkg;

  localparam int PIPE_WIDTH_DEF  = 64;
  localparam int PIPE_STAGES_DEF = 4;

  // Occupancy must represent 0..stages inclusive.
  function automatic int cnt_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid/data slot: allowin/go handshake with flush overriding the valid update.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_bus,
  input  logic             next_allowin,
  input  logic             ready_go,
  input  logic             flush,
  output logic             go,
  output logic             v_nxt,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             allowin;

  always_comb begin
    allowin = !v_q || (ready_go && next_allowin);
    go      = v_q && ready_go;
    v_d     = v_q;
    d_d     = d_q;
    if (allowin)             v_d = src_valid;
    if (src_valid && allowin) d_d = src_bus;
    // The sender still completes its handshake; only the landing copy dies.
    if (flush)               v_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_nxt = v_d;
  assign v     = v_q;
  assign d     = d_q;

endmodule

// File: rtl/pipe_chain.sv
// Chain of STAGES valid/allowin slots with per-slot ready-go, flush and taps.
module pipe_chain
  import pipe_pkg::*;
#(
  parameter  int WIDTH  = PIPE_WIDTH_DEF,
  parameter  int STAGES = PIPE_STAGES_DEF,
  localparam int CNT_W  = cnt_w(STAGES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_bus,
  output logic                    in_allowin,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_bus,
  input  logic                    out_allowin,
  input  logic [STAGES-1:0]       ready_go,
  input  logic [STAGES-1:0]       flush,
  output logic [STAGES-1:0]       tap_valid,
  output logic [STAGES*WIDTH-1:0] tap_bus,
  output logic [CNT_W-1:0]        occupancy
);

  logic [STAGES-1:0] nxt_ain, go, src_vld, v_nxt;
  logic [CNT_W-1:0]  occ_q, occ_d;

  // Allowin ripples from the output back to slot 0; built in one block so
  // each slot sees its downstream allowin without a self-referencing vector.
  always_comb begin
    logic ain;
    ain = out_allowin;
    for (int i = STAGES - 1; i >= 0; i--) begin
      nxt_ain[i] = ain;
      ain = !tap_valid[i] || (ready_go[i] && ain);
    end
    in_allowin = ain;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    logic [WIDTH-1:0] sbus;
    if (i == 0) begin : g_head
      assign src_vld[i] = in_valid;
      assign sbus       = in_bus;
    end else begin : g_body
      assign src_vld[i] = go[i-1];
      assign sbus       = tap_bus[(i-1)*WIDTH +: WIDTH];
    end

    pipe_slot #(.WIDTH(WIDTH)) u_slot (
      .clk          (clk),
      .reset        (reset),
      .src_valid    (src_vld[i]),
      .src_bus      (sbus),
      .next_allowin (nxt_ain[i]),
      .ready_go     (ready_go[i]),
      .flush        (flush[i]),
      .go           (go[i]),
      .v_nxt        (v_nxt[i]),
      .v            (tap_valid[i]),
      .d            (tap_bus[i*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) occ_d = occ_d + CNT_W'(v_nxt[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign occupancy = occ_q;
  assign out_valid = go[STAGES-1];
  assign out_bus   = tap_bus[(STAGES-1)*WIDTH +: WIDTH];

endmodule
